// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data and memory-side signals of the
// two-requester memory arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives the rest)
//   master : requester/memory side (drives requests and mem_rdata)
// Fetch group : if_req, if_addr, if_flush -> if_rdata, if_valid, pc_stall
// Data group  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_valid, dm_stall
// Memory group: mem_en, mem_we, mem_addr, mem_wdata <- mem_rdata
// Status      : busy
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              pc_stall;
    logic              dm_stall;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output pc_stall, dm_stall, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  pc_stall, dm_stall, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch (IF)
// and data access (DM). Each access holds the memory for WAIT_CYCLES+1
// cycles; the owner then gets a one-cycle valid pulse with its read data.
// All state changes on the falling edge of clk.
// Ports:
//   clk  - clock (falling edge active)
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave: fetch/data request groups, memory side,
//          stall indications and busy
module mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int DM_PRIORITY = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_valid_q, if_valid_d;
    logic              dm_valid_q, dm_valid_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic complete;
    logic arb_en;
    logic cand_if;
    logic cand_dm;
    logic grant_dm;
    logic grant_if;
    logic drop_eff;

    assign complete = (state_q != IDLE) && (cnt_q == 3'd0);
    assign arb_en   = (state_q == IDLE) || complete;
    // The requester being completed sits out the arbitration at its own
    // completion edge, so a busy pair alternates and a lone requester
    // sees one idle cycle (its valid cycle) between accesses.
    assign cand_if  = bus.if_req && !(complete && (state_q == IF_ACC));
    assign cand_dm  = bus.dm_req && !(complete && (state_q == DM_ACC));
    assign grant_dm = arb_en && cand_dm && ((DM_PRIORITY != 0) || !cand_if);
    assign grant_if = arb_en && cand_if && !grant_dm;
    // A flush sampled on the completion edge itself also drops the fetch.
    assign drop_eff = drop_q || bus.if_flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if ((state_q == IF_ACC) && bus.if_flush) begin
            drop_d = 1'b1;
        end

        if ((state_q != IDLE) && !complete) begin
            cnt_d = cnt_q - 3'd1;
        end

        if (complete) begin
            if (state_q == IF_ACC) begin
                if (!drop_eff) begin
                    if_rdata_d = bus.mem_rdata;
                    if_valid_d = 1'b1;
                end
            end else begin
                dm_valid_d = 1'b1;
                if (!mem_we_q) begin
                    dm_rdata_d = bus.mem_rdata;
                end
            end
        end

        if (grant_dm) begin
            state_d     = DM_ACC;
            cnt_d       = WAIT_INIT;
            mem_en_d    = 1'b1;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
        end else if (grant_if) begin
            state_d    = IF_ACC;
            cnt_d      = WAIT_INIT;
            mem_en_d   = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = bus.if_addr;
            drop_d     = bus.if_flush;
        end else if (complete) begin
            state_d  = IDLE;
            mem_en_d = 1'b0;
            mem_we_d = 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            drop_q      <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.pc_stall  = bus.if_req & ~if_valid_q;
    assign bus.dm_stall  = bus.dm_req & ~dm_valid_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: two instances (A: WAIT_CYCLES=1, DM_PRIORITY=1;
// B: WAIT_CYCLES=0, DM_PRIORITY=0) share one stimulus stream. A
// transaction-level reference model predicts every output of both each cycle.
module tb_mem_arbiter;
    logic clk;
    logic r_rst;
    logic r_if_req, r_if_flush, r_dm_req, r_dm_we;
    logic [7:0] r_if_addr, r_dm_addr, r_dm_wdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifa ();
    mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) ifb ();

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1), .DM_PRIORITY(1))
        dut_a (.clk(clk), .rst(r_rst), .bus(ifa));
    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0), .DM_PRIORITY(0))
        dut_b (.clk(clk), .rst(r_rst), .bus(ifb));

    assign ifa.if_req   = r_if_req;   assign ifb.if_req   = r_if_req;
    assign ifa.if_addr  = r_if_addr;  assign ifb.if_addr  = r_if_addr;
    assign ifa.if_flush = r_if_flush; assign ifb.if_flush = r_if_flush;
    assign ifa.dm_req   = r_dm_req;   assign ifb.dm_req   = r_dm_req;
    assign ifa.dm_we    = r_dm_we;    assign ifb.dm_we    = r_dm_we;
    assign ifa.dm_addr  = r_dm_addr;  assign ifb.dm_addr  = r_dm_addr;
    assign ifa.dm_wdata = r_dm_wdata; assign ifb.dm_wdata = r_dm_wdata;

    initial clk = 1'b1;
    always #5 clk = ~clk;

    function automatic logic [7:0] memval(input int i);
        case (i)
            'h10:    return 8'hA5;
            'h40:    return 8'h77;
            'h08:    return 8'h99;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // Bench-side memories, one per instance
    logic [7:0] bmem_a [256];
    logic [7:0] bmem_b [256];
    bit mem_init = 1'b0;
    assign ifa.mem_rdata = bmem_a[ifa.mem_addr];
    assign ifb.mem_rdata = bmem_b[ifb.mem_addr];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) begin
                bmem_a[i] <= memval(i);
                bmem_b[i] <= memval(i);
            end
            mem_init <= 1'b1;
        end else begin
            if (ifa.mem_en && ifa.mem_we) bmem_a[ifa.mem_addr] <= ifa.mem_wdata;
            if (ifb.mem_en && ifb.mem_we) bmem_b[ifb.mem_addr] <= ifb.mem_wdata;
        end
    end

    // Reference model: one outstanding transaction per instance, finishing
    // WAIT_CYCLES+1 edges after the edge that granted it.
    bit         m_act  [2];
    bit         m_dm   [2];
    bit         m_we   [2];
    bit         m_drop [2];
    logic [7:0] m_addr [2];
    logic [7:0] m_wd   [2];
    int         m_done_at [2];
    int         m_now = 0;
    logic [7:0] mmem [2][256];
    bit         e_if_valid [2], e_dm_valid [2], e_mem_en [2], e_mem_we [2];
    logic [7:0] e_if_rdata [2], e_dm_rdata [2], e_mem_addr [2], e_mem_wdata [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) mmem[d][i] = memval(i);
            m_act[d] = 0; m_dm[d] = 0; m_we[d] = 0; m_drop[d] = 0;
            m_addr[d] = 0; m_wd[d] = 0; m_done_at[d] = 0;
            e_if_valid[d] = 0; e_dm_valid[d] = 0; e_mem_en[d] = 0; e_mem_we[d] = 0;
            e_if_rdata[d] = 0; e_dm_rdata[d] = 0; e_mem_addr[d] = 0; e_mem_wdata[d] = 0;
        end
    end

    task automatic model_step(input int d);
        int  waitc;
        bit  dm_first, done, ci, cd;
        waitc    = (d == 0) ? 1 : 0;
        dm_first = (d == 0);
        // an active store is writing the memory at every edge it spans
        if (m_act[d] && m_dm[d] && m_we[d]) mmem[d][m_addr[d]] = m_wd[d];
        e_if_valid[d] = 0;
        e_dm_valid[d] = 0;
        if (r_rst) begin
            m_act[d] = 0; m_drop[d] = 0;
            e_if_rdata[d] = 0; e_dm_rdata[d] = 0; e_mem_en[d] = 0;
            e_mem_we[d] = 0; e_mem_addr[d] = 0; e_mem_wdata[d] = 0;
            return;
        end
        done = m_act[d] && (m_now == m_done_at[d]);
        if (m_act[d] && !m_dm[d] && r_if_flush) m_drop[d] = 1;
        if (done) begin
            if (m_dm[d]) begin
                e_dm_valid[d] = 1;
                if (!m_we[d]) e_dm_rdata[d] = mmem[d][m_addr[d]];
            end else if (!m_drop[d]) begin
                e_if_valid[d] = 1;
                e_if_rdata[d] = mmem[d][m_addr[d]];
            end
        end
        if (!m_act[d] || done) begin
            ci = r_if_req && !(done && !m_dm[d]);
            cd = r_dm_req && !(done && m_dm[d]);
            if (cd && (dm_first || !ci)) begin
                m_act[d] = 1; m_dm[d] = 1; m_we[d] = r_dm_we;
                m_addr[d] = r_dm_addr; m_wd[d] = r_dm_wdata;
                m_done_at[d] = m_now + waitc + 1;
                e_mem_en[d] = 1; e_mem_we[d] = r_dm_we;
                e_mem_addr[d] = r_dm_addr; e_mem_wdata[d] = r_dm_wdata;
            end else if (ci) begin
                m_act[d] = 1; m_dm[d] = 0; m_we[d] = 0;
                m_addr[d] = r_if_addr; m_drop[d] = r_if_flush;
                m_done_at[d] = m_now + waitc + 1;
                e_mem_en[d] = 1; e_mem_we[d] = 0; e_mem_addr[d] = r_if_addr;
            end else begin
                m_act[d] = 0; e_mem_en[d] = 0; e_mem_we[d] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
        m_now++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic cmp_model(input string tag, input int d,
                             input logic [7:0] ird, input logic iv,
                             input logic [7:0] drd, input logic dv,
                             input logic en, input logic we,
                             input logic [7:0] ad, input logic [7:0] wd,
                             input logic ps, input logic ds, input logic bz);
        chk({tag, ".if_rdata"},  32'(ird), 32'(e_if_rdata[d]));
        chk({tag, ".if_valid"},  32'(iv),  32'(e_if_valid[d]));
        chk({tag, ".dm_rdata"},  32'(drd), 32'(e_dm_rdata[d]));
        chk({tag, ".dm_valid"},  32'(dv),  32'(e_dm_valid[d]));
        chk({tag, ".mem_en"},    32'(en),  32'(e_mem_en[d]));
        chk({tag, ".mem_we"},    32'(we),  32'(e_mem_we[d]));
        chk({tag, ".mem_addr"},  32'(ad),  32'(e_mem_addr[d]));
        chk({tag, ".mem_wdata"}, 32'(wd),  32'(e_mem_wdata[d]));
        chk({tag, ".pc_stall"},  32'(ps),  32'(r_if_req & ~e_if_valid[d]));
        chk({tag, ".dm_stall"},  32'(ds),  32'(r_dm_req & ~e_dm_valid[d]));
        chk({tag, ".busy"},      32'(bz),  32'(m_act[d]));
    endtask

    // Inputs change just after the rising edge; the arbiters act on the
    // falling edge; outputs are compared at the following rising edge.
    task automatic tick();
        @(posedge clk);
        cmp_model("A", 0, ifa.if_rdata, ifa.if_valid, ifa.dm_rdata, ifa.dm_valid,
                  ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_wdata,
                  ifa.pc_stall, ifa.dm_stall, ifa.busy);
        cmp_model("B", 1, ifb.if_rdata, ifb.if_valid, ifb.dm_rdata, ifb.dm_valid,
                  ifb.mem_en, ifb.mem_we, ifb.mem_addr, ifb.mem_wdata,
                  ifb.pc_stall, ifb.dm_stall, ifb.busy);
        #1;
    endtask

    task automatic drive(input int rst, input int ireq, input int iaddr, input int flush,
                         input int dreq, input int we, input int daddr, input int wd);
        r_rst = 1'(rst); r_if_req = 1'(ireq); r_if_addr = 8'(iaddr);
        r_if_flush = 1'(flush); r_dm_req = 1'(dreq); r_dm_we = 1'(we);
        r_dm_addr = 8'(daddr); r_dm_wdata = 8'(wd);
    endtask

    // Directed vectors for instance A (WAIT_CYCLES=1, DM_PRIORITY=1):
    // inputs for one cycle, then A's outputs after that cycle's edge.
    typedef struct {
        int rst, ireq, iaddr, flush, dreq, we, daddr, wd;
        int x_iv, x_ird, x_dv, x_drd, x_en, x_we, x_addr, x_wd, x_busy;
    } vec_t;

    vec_t vecs [29];

    initial begin
        //           rst ireq iaddr fl dreq we daddr wd    iv ird   dv drd   en we addr  wd    busy
        vecs[0]  = '{1, 1, 'h10, 0, 1, 0, 'h20, 'h00,  0, 'h00, 0, 'h00, 0, 0, 'h00, 'h00, 0};
        vecs[1]  = '{1, 1, 'h10, 0, 1, 0, 'h20, 'h00,  0, 'h00, 0, 'h00, 0, 0, 'h00, 'h00, 0};
        vecs[2]  = '{0, 1, 'h10, 0, 0, 0, 'h20, 'h00,  0, 'h00, 0, 'h00, 1, 0, 'h10, 'h00, 1};
        vecs[3]  = '{0, 1, 'h10, 0, 0, 0, 'h20, 'h00,  0, 'h00, 0, 'h00, 1, 0, 'h10, 'h00, 1};
        vecs[4]  = '{0, 1, 'h10, 0, 0, 0, 'h20, 'h00,  1, 'hA5, 0, 'h00, 0, 0, 'h10, 'h00, 0};
        vecs[5]  = '{0, 0, 'h10, 0, 0, 0, 'h20, 'h00,  0, 'hA5, 0, 'h00, 0, 0, 'h10, 'h00, 0};
        vecs[6]  = '{0, 0, 'h10, 0, 1, 1, 'h20, 'h3C,  0, 'hA5, 0, 'h00, 1, 1, 'h20, 'h3C, 1};
        vecs[7]  = '{0, 0, 'h10, 0, 1, 1, 'h20, 'h3C,  0, 'hA5, 0, 'h00, 1, 1, 'h20, 'h3C, 1};
        vecs[8]  = '{0, 0, 'h10, 0, 1, 1, 'h20, 'h3C,  0, 'hA5, 1, 'h00, 0, 0, 'h20, 'h3C, 0};
        vecs[9]  = '{0, 0, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h00, 1, 0, 'h20, 'h3C, 1};
        vecs[10] = '{0, 0, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h00, 1, 0, 'h20, 'h3C, 1};
        vecs[11] = '{0, 0, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 1, 'h3C, 0, 0, 'h20, 'h3C, 0};
        vecs[12] = '{0, 0, 'h10, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 0, 0, 'h20, 'h3C, 0};
        vecs[13] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h20, 'h3C, 1};
        vecs[14] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h20, 'h3C, 1};
        vecs[15] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 1, 'h3C, 1, 0, 'h10, 'h3C, 1};
        vecs[16] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h10, 'h3C, 1};
        vecs[17] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  1, 'hA5, 0, 'h3C, 1, 0, 'h20, 'h3C, 1};
        vecs[18] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h20, 'h3C, 1};
        vecs[19] = '{0, 1, 'h10, 0, 1, 0, 'h20, 'h3C,  0, 'hA5, 1, 'h3C, 1, 0, 'h10, 'h3C, 1};
        vecs[20] = '{0, 1, 'h10, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h10, 'h3C, 1};
        vecs[21] = '{0, 1, 'h10, 0, 0, 0, 'h20, 'h3C,  1, 'hA5, 0, 'h3C, 0, 0, 'h10, 'h3C, 0};
        vecs[22] = '{0, 1, 'h40, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h40, 'h3C, 1};
        vecs[23] = '{0, 1, 'h40, 1, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h40, 'h3C, 1};
        vecs[24] = '{0, 1, 'h40, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 0, 0, 'h40, 'h3C, 0};
        vecs[25] = '{0, 1, 'h08, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h08, 'h3C, 1};
        vecs[26] = '{0, 1, 'h08, 0, 0, 0, 'h20, 'h3C,  0, 'hA5, 0, 'h3C, 1, 0, 'h08, 'h3C, 1};
        vecs[27] = '{0, 1, 'h08, 0, 0, 0, 'h20, 'h3C,  1, 'h99, 0, 'h3C, 0, 0, 'h08, 'h3C, 0};
        vecs[28] = '{0, 0, 'h08, 0, 0, 0, 'h20, 'h3C,  0, 'h99, 0, 'h3C, 0, 0, 'h08, 'h3C, 0};

        drive(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].rst, vecs[i].ireq, vecs[i].iaddr, vecs[i].flush,
                  vecs[i].dreq, vecs[i].we, vecs[i].daddr, vecs[i].wd);
            tick();
            chk($sformatf("vec%0d.if_valid", i),  32'(ifa.if_valid),  32'(vecs[i].x_iv));
            chk($sformatf("vec%0d.if_rdata", i),  32'(ifa.if_rdata),  32'(vecs[i].x_ird));
            chk($sformatf("vec%0d.dm_valid", i),  32'(ifa.dm_valid),  32'(vecs[i].x_dv));
            chk($sformatf("vec%0d.dm_rdata", i),  32'(ifa.dm_rdata),  32'(vecs[i].x_drd));
            chk($sformatf("vec%0d.mem_en", i),    32'(ifa.mem_en),    32'(vecs[i].x_en));
            chk($sformatf("vec%0d.mem_we", i),    32'(ifa.mem_we),    32'(vecs[i].x_we));
            chk($sformatf("vec%0d.mem_addr", i),  32'(ifa.mem_addr),  32'(vecs[i].x_addr));
            chk($sformatf("vec%0d.mem_wdata", i), 32'(ifa.mem_wdata), 32'(vecs[i].x_wd));
            chk($sformatf("vec%0d.busy", i),      32'(ifa.busy),      32'(vecs[i].x_busy));
            chk($sformatf("vec%0d.pc_stall", i),  32'(ifa.pc_stall),
                32'((vecs[i].ireq != 0 && vecs[i].x_iv == 0) ? 1 : 0));
        end

        // Reset in the middle of A's fetch (one wait cycle still pending)
        drive(0, 1, 'h10, 0, 0, 0, 'h20, 'h3C);
        tick();
        chk("midrst.grant_busy", 32'(ifa.busy), 32'd1);
        drive(1, 1, 'h10, 0, 0, 0, 'h20, 'h3C);
        tick();
        chk("midrst.busy",   32'(ifa.busy),   32'd0);
        chk("midrst.mem_en", 32'(ifa.mem_en), 32'd0);
        drive(0, 0, 'h10, 0, 0, 0, 'h20, 'h3C);
        tick();
        chk("midrst.if_valid", 32'(ifa.if_valid), 32'd0);
        chk("midrst.if_rdata", 32'(ifa.if_rdata), 32'd0);

        // B (IF priority, no wait): simultaneous requests serve IF first
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 'h10, 0, 1, 0, 'h20, 'h00);
        tick();
        chk("B.tie.first_addr", 32'(ifb.mem_addr), 32'h10);
        tick();
        chk("B.tie.if_valid",    32'(ifb.if_valid), 32'd1);
        chk("B.tie.if_rdata",    32'(ifb.if_rdata), 32'hA5);
        chk("B.tie.second_addr", 32'(ifb.mem_addr), 32'h20);

        // B: lone fetch requester gets one idle cycle between accesses
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 1, 'h10, 0, 0, 0, 'h20, 'h00);
        tick();
        chk("B.lone.busy1",  32'(ifb.busy),     32'd1);
        chk("B.lone.valid1", 32'(ifb.if_valid), 32'd0);
        tick();
        chk("B.lone.busy2",  32'(ifb.busy),     32'd0);
        chk("B.lone.valid2", 32'(ifb.if_valid), 32'd1);
        tick();
        chk("B.lone.busy3",  32'(ifb.busy),     32'd1);
        chk("B.lone.valid3", 32'(ifb.if_valid), 32'd0);
        tick();
        chk("B.lone.valid4", 32'(ifb.if_valid), 32'd1);
        chk("B.lone.rdata4", 32'(ifb.if_rdata), 32'hA5);

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            r_rst      = ($urandom_range(0, 63) == 0);
            r_if_req   = ($urandom_range(0, 3) != 0);
            r_if_addr  = 8'($urandom);
            r_if_flush = ($urandom_range(0, 7) == 0);
            r_dm_req   = ($urandom_range(0, 2) != 0);
            r_dm_we    = 1'($urandom);
            r_dm_addr  = 8'($urandom_range(0, 15));
            r_dm_wdata = 8'($urandom);
            tick();
            chk("A.valid_exclusive", 32'(ifa.if_valid & ifa.dm_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port 8-bit memory between two requesters: instruction fetch (IF) and data memory access (DM, i.e. LOAD/STORE).
- Sequences each access over a configurable number of wait cycles and returns read data with a one-cycle valid pulse.
- Generates stall indications for the program counter and pipeline, and supports dropping an in-flight fetch when a branch redirects.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- WAIT_CYCLES, 1, extra memory cycles per access (legal range 0..7); an access occupies the memory for WAIT_CYCLES+1 cycles.
- DM_PRIORITY, 1, tie rule: 1 means DM wins simultaneous requests; 0 means IF wins.

Ports:
- clk  in  1  single clock; all state updates on the falling edge of clk.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request, level; held until if_valid.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_flush  in  1  branch redirect: discard the result of the in-flight fetch.
- if_rdata  out  DATA_W  fetched instruction byte.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- dm_req  in  1  data request, level; held until dm_valid.
- dm_we  in  1  1 = STORE, 0 = LOAD.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data.
- dm_valid  out  1  one-cycle pulse; access complete (loads and stores).
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid in the last cycle of an access.
- pc_stall  out  1  combinational: if_req & ~if_valid.
- dm_stall  out  1  combinational: dm_req & ~dm_valid.
- busy  out  1  high when state is not IDLE.

Behaviour:
- States: IDLE, IF_ACC, DM_ACC. The wait counter cnt is 3 bits.
- Reset (rst high at an edge):
  - state = IDLE, cnt = 0, drop flag = 0.
  - All registered outputs become 0: if_rdata, dm_rdata, if_valid, dm_valid, mem_en, mem_we, mem_addr, mem_wdata.
  - Any in-flight access is abandoned with no valid pulse; requests sampled at that same edge are ignored.
- Arbitration runs at every edge where state is IDLE or an access completes.
  - Candidates are if_req and dm_req; ties are resolved by DM_PRIORITY.
  - At a completion edge, the requester being completed is excluded. Consequences:
    - A continuously requesting pair alternates.
    - A lone requester gets one idle cycle between its accesses.
- Grant:
  - Latch address (and, for DM, we and wdata) into mem_addr, mem_we, mem_wdata.
  - Set mem_en = 1, cnt = WAIT_CYCLES, and enter IF_ACC or DM_ACC.
  - For an IF grant, the drop flag is cleared.
- In an ACC state, at each edge:
  - If cnt != 0: cnt decrements.
  - If cnt == 0: completion. mem_rdata is captured into the owner's rdata, the owner's valid is pulsed for the next cycle, and re-arbitration runs. With no grant, state returns to IDLE with mem_en = 0 and mem_we = 0.
- Timing: the grant edge is E0, completion is edge E0+WAIT_CYCLES+1, and valid is high for the cycle that follows. Back-to-back accesses to different requesters have no gap.
- Stores:
  - mem_we is high for the whole access.
  - dm_rdata is not updated; dm_valid still pulses.
- In IDLE, mem_addr and mem_wdata hold their last values.
- Flush:
  - if_flush sampled high while state is IF_ACC sets the drop flag.
  - At completion with the drop flag set, the memory access still finishes, but if_rdata is not updated and if_valid stays 0.
  - if_flush in IDLE or DM_ACC has no effect.
  - if_flush at the IF grant edge drops that fetch.
- Requests are never queued internally. A request deasserted before grant is lost, which is legal.
- if_valid and dm_valid are never high in the same cycle.

Test Plan:
- Reset: rst for 2 edges, with requests active -> all outputs 0, busy = 0, mem_en = 0. Mid-access reset (IF_ACC, cnt = 1) -> IDLE next edge, no if_valid pulse.
- Single fetch, WAIT_CYCLES = 1: if_addr = 0x10, memory returns 0xA5 -> mem_en high 2 cycles with mem_addr = 0x10, then if_valid for 1 cycle with if_rdata = 0xA5. pc_stall is high from request until valid.
- Store then load: store 0x3C at 0x20 -> mem_we = 1 for 2 cycles, mem_wdata = 0x3C, dm_valid pulse. Then load from 0x20 -> dm_rdata = 0x3C, mem_we = 0.
- Simultaneous if_req and dm_req, DM_PRIORITY = 1, both held -> grant order DM, IF, DM, IF with no idle gap. With DM_PRIORITY = 0 -> order IF first.
- Flush: fetch at 0x40, if_flush high during IF_ACC -> memory access completes, if_valid stays 0, if_rdata unchanged. A new fetch at 0x08 then returns normally.
- WAIT_CYCLES = 0: fetch completes at the edge after grant. Lone requester re-requesting -> one IDLE cycle between its two accesses.
